mem_read_port: RTL and testbench
================================

MEM_READ_PORT -- requirements
Module: mem_read_port

Interface
REQ-001 Parameter q0, default 0: value held in the data register after clr.
REQ-002 Parameter TIMEOUT, default 16: WAIT cycles without mem_ack before the read aborts; legal range 1..255.
REQ-003 Parameter ERR_DATA, default 32'hDEADBEEF: data substituted on timeout.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 clr  in  1  asynchronous, active-high reset.
REQ-006 rd_start  in  1  read request; sampled only in IDLE.
REQ-007 addr  in  32  read address; sampled together with rd_start.
REQ-008 mem_ack  in  1  memory responder: mem_rdata valid this cycle.
REQ-009 mem_rdata  in  32  memory read data.
REQ-010 bus_grant  in  1  bus controller permits this block to drive BusMuxIn.
REQ-011 mem_req  out  1  registered read request to memory.
REQ-012 mem_addr  out  32  registered address to memory.
REQ-013 bus_out  out  32  data onto BusMuxIn; 0 when not driving.
REQ-014 bus_drive  out  1  this block is driving bus_out this cycle.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse after the bus transfer.
REQ-017 timeout_err  out  1  sticky flag: the last read timed out.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, WAIT, DRIVE.
REQ-019 IDLE, rd_start=1 at edge N: from N+1, state=WAIT, mem_req=1, mem_addr=addr, wait counter=0, timeout_err=0.
REQ-020 rd_start SHALL be ignored in WAIT and DRIVE, with no queuing.
REQ-021 mem_ack SHALL be ignored in IDLE and DRIVE.
REQ-022 WAIT, mem_ack=1: next edge captures mem_rdata into the data register, sets mem_req=0 and enters DRIVE.
REQ-023 WAIT, mem_ack=0: the 8-bit counter SHALL increment each cycle.
REQ-024 WAIT, mem_ack=0 and counter==TIMEOUT-1: next edge loads ERR_DATA, sets timeout_err=1 and mem_req=0, and enters DRIVE.
REQ-025 If mem_ack=1 and the timeout condition occur in the same cycle, mem_ack SHALL win, and timeout_err stays 0.
REQ-026 bus_drive SHALL be combinational: (state==DRIVE) & bus_grant.
REQ-027 bus_out SHALL equal the data register when bus_drive=1, else 32'h0.
REQ-028 DRIVE SHALL hold, with the data register stable, for any number of cycles while bus_grant=0.
REQ-029 DRIVE, bus_grant=1 at edge M: that cycle is the transfer; at M+1, state=IDLE and done=1 for exactly one cycle.
REQ-030 mem_addr and the data register SHALL hold their last values in IDLE.
REQ-031 Minimum latency: rd_start accepted at edge N, mem_ack seen at N+1, bus_grant held high → bus_drive during cycle N+2, done during cycle N+3.

Reset
REQ-032 clr=1 SHALL, immediately and regardless of clk, set state=IDLE, mem_req=0, mem_addr=0, data register=q0, counter=0, done=0 and timeout_err=0; consequently busy=0, bus_drive=0 and bus_out=0.
REQ-033 clr asserted mid-WAIT or mid-DRIVE SHALL abort the read without a done pulse; the next rd_start after clr deasserts SHALL be accepted normally.

Verification
REQ-034 Nominal read: addr=0x100, rd_start pulse, mem_ack one cycle later with mem_rdata=0x12345678, bus_grant=1 → bus_out=0x12345678 with bus_drive=1 for one cycle, done pulse next cycle, timeout_err=0.
REQ-035 Grant stall: as REQ-034 but bus_grant held 0 for 5 cycles in DRIVE → bus_out=0 and busy=1 throughout the stall; transfer and done follow the first cycle of bus_grant=1.
REQ-036 Timeout: TIMEOUT=4, no mem_ack → mem_req high for exactly 4 cycles, then bus_out=0xDEADBEEF on grant, timeout_err=1; timeout_err clears on the next accepted rd_start.
REQ-037 Ack/timeout collision: TIMEOUT=4, mem_ack on the 4th WAIT cycle with mem_rdata=0xA5A5A5A5 → bus_out=0xA5A5A5A5, timeout_err=0.
REQ-038 Ignored requests: rd_start with addr=0x200 pulsed during WAIT, and mem_ack pulsed during IDLE → mem_addr keeps its previous value and no extra transaction starts.
REQ-039 Async clear: clr raised between clock edges during WAIT → mem_req=0 and busy=0 before the next edge, no done pulse; a fresh read afterwards completes per REQ-034.

Source files
------------

// File: rtl/mem_read_port_if.sv
// mem_read_port handshake and bus signals.
// slave: the read port; master: requester, memory and bus side.
interface mem_read_port_if;
  logic        rd_start;
  logic [31:0] addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_grant;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] bus_out;
  logic        bus_drive;
  logic        busy;
  logic        done;
  logic        timeout_err;

  modport slave (
    input  rd_start, addr, mem_ack, mem_rdata, bus_grant,
    output mem_req, mem_addr, bus_out, bus_drive,
    output busy, done, timeout_err
  );

  modport master (
    output rd_start, addr, mem_ack, mem_rdata, bus_grant,
    input  mem_req, mem_addr, bus_out, bus_drive,
    input  busy, done, timeout_err
  );
endinterface

// File: rtl/mem_read_port.sv
// Single-word memory read port: request, wait with timeout,
// then hold the word until the bus grants a transfer.
module mem_read_port #(
  parameter logic [31:0] q0       = 32'h0,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input logic           clk,
  input logic           clr,
  mem_read_port_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRIVE
  } state_t;

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_n;
  logic        req_q, req_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] data_q, data_n;
  logic [7:0]  cnt_q, cnt_n;
  logic        done_q, done_n;
  logic        terr_q, terr_n;

  // State and datapath registers; clr aborts any read at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= q0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      cnt_q   <= cnt_n;
      done_q  <= done_n;
      terr_q  <= terr_n;
    end
  end

  // Next state; an ack takes priority over a same-cycle timeout.
  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    addr_n  = addr_q;
    data_n  = data_q;
    cnt_n   = cnt_q;
    done_n  = 1'b0;
    terr_n  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.rd_start) begin
          state_n = WAIT;
          req_n   = 1'b1;
          addr_n  = bus.addr;
          cnt_n   = '0;
          terr_n  = 1'b0;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          state_n = DRIVE;
          req_n   = 1'b0;
          data_n  = bus.mem_rdata;
        end else if (cnt_q == TLAST) begin
          state_n = DRIVE;
          req_n   = 1'b0;
          data_n  = ERR_DATA;
          terr_n  = 1'b1;
        end else begin
          cnt_n = cnt_q + 8'd1;
        end
      end
      DRIVE: begin
        if (bus.bus_grant) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.bus_drive   = (state_q == DRIVE) & bus.bus_grant;
  assign bus.bus_out     = bus.bus_drive ? data_q : 32'h0;
  assign bus.busy        = (state_q != IDLE);
  assign bus.mem_req     = req_q;
  assign bus.mem_addr    = addr_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_mem_read_port.sv
// Self-checking bench for mem_read_port: vector table plus
// hand-written ignore and async-clear sequences.
module tb_mem_read_port;

  localparam int TO = 4;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  mem_read_port_if bus ();

  mem_read_port #(
    .q0      (32'h0),
    .TIMEOUT (TO),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          ack_dly;
    int          grant_dly;
    logic [31:0] exp_data;
    logic        exp_terr;
  } vec_t;

  vec_t        tbl[6];
  logic [32:0] sbq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input vec_t v);
    int          n;
    int          exp_n;
    logic        stall_ok;
    logic [32:0] e;
    bus.rd_start = 1'b1;
    bus.addr     = v.addr;
    tick();
    bus.rd_start = 1'b0;
    bus.addr     = 32'h0;
    chk("acc_req", 32'(bus.mem_req), 32'd1);
    chk("acc_addr", bus.mem_addr, v.addr);
    chk("acc_busy", 32'(bus.busy), 32'd1);
    chk("acc_terr", 32'(bus.timeout_err), 32'd0);
    sbq.push_back({v.exp_terr, v.exp_data});
    exp_n = ((v.ack_dly < TO - 1) ? v.ack_dly : TO - 1) + 1;
    n = 0;
    for (int k = 0; k < 300; k++) begin
      if (k == v.ack_dly) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.rdata;
      end
      tick();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = ~v.rdata;
      n++;
      if (!bus.mem_req) break;
    end
    chk("req_cycles", 32'(n), 32'(exp_n));
    stall_ok = 1'b1;
    for (int g = 0; g < v.grant_dly; g++) begin
      bus.bus_grant = 1'b0;
      bus.mem_ack   = (g == 0);
      #1;
      stall_ok &= (bus.bus_out == 32'h0) && !bus.bus_drive && bus.busy;
      tick();
      bus.mem_ack = 1'b0;
    end
    if (v.grant_dly > 0) chk("stall", 32'(stall_ok), 32'd1);
    bus.bus_grant = 1'b1;
    #1;
    chk("drive", 32'(bus.bus_drive), 32'd1);
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("bus_out", bus.bus_out, e[31:0]);
      chk("terr", 32'(bus.timeout_err), 32'(e[32]));
    end
    tick();
    bus.bus_grant = 1'b0;
    chk("done", 32'(bus.done), 32'd1);
    chk("idle", 32'(bus.busy), 32'd0);
    tick();
    chk("done_off", 32'(bus.done), 32'd0);
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    tbl[0] = '{32'h100, 32'h12345678, 0, 0, 32'h12345678, 1'b0};
    tbl[1] = '{32'h104, 32'hCAFEF00D, 0, 5, 32'hCAFEF00D, 1'b0};
    tbl[2] = '{32'h108, 32'h11111111, 255, 2, 32'hDEADBEEF, 1'b1};
    tbl[3] = '{32'h10C, 32'hA5A5A5A5, 3, 0, 32'hA5A5A5A5, 1'b0};
    tbl[4] = '{32'h110, 32'h0F0F0F0F, 2, 1, 32'h0F0F0F0F, 1'b0};
    tbl[5] = '{32'hFFFFFFFC, 32'hFFFFFFFF, 255, 0, 32'hDEADBEEF, 1'b1};

    clr           = 1'b1;
    bus.rd_start  = 1'b0;
    bus.addr      = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.bus_grant = 1'b1;
    #2;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_drive", 32'(bus.bus_drive), 32'd0);
    chk("rst_out", bus.bus_out, 32'h0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_terr", 32'(bus.timeout_err), 32'd0);
    tick();
    clr           = 1'b0;
    bus.bus_grant = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) do_read(tbl[i]);
    chk("terr_sticky", 32'(bus.timeout_err), 32'd1);

    bus.rd_start = 1'b1;
    bus.addr     = 32'h300;
    tick();
    bus.rd_start = 1'b1;
    bus.addr     = 32'h200;
    tick();
    bus.rd_start = 1'b0;
    chk("ign_addr", bus.mem_addr, 32'h300);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h3C3C3C3C;
    tick();
    bus.mem_ack  = 1'b0;
    bus.rd_start = 1'b1;
    bus.addr     = 32'h204;
    tick();
    bus.rd_start  = 1'b0;
    bus.bus_grant = 1'b1;
    #1;
    chk("ign_out", bus.bus_out, 32'h3C3C3C3C);
    tick();
    bus.bus_grant = 1'b0;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("ign_ack_busy", 32'(bus.busy), 32'd0);
    chk("ign_ack_req", 32'(bus.mem_req), 32'd0);
    chk("ign_hold_addr", bus.mem_addr, 32'h300);

    bus.rd_start = 1'b1;
    bus.addr     = 32'h400;
    tick();
    bus.rd_start = 1'b0;
    tick();
    #2;
    clr = 1'b1;
    #1;
    chk("aclr_req", 32'(bus.mem_req), 32'd0);
    chk("aclr_busy", 32'(bus.busy), 32'd0);
    tick();
    clr = 1'b0;
    chk("aclr_done", 32'(bus.done), 32'd0);
    tick();
    chk("aclr_done2", 32'(bus.done), 32'd0);

    bus.rd_start = 1'b1;
    bus.addr     = 32'h500;
    tick();
    bus.rd_start  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55AA55AA;
    tick();
    bus.mem_ack = 1'b0;
    #2;
    clr           = 1'b1;
    bus.bus_grant = 1'b1;
    #1;
    chk("dclr_drive", 32'(bus.bus_drive), 32'd0);
    chk("dclr_busy", 32'(bus.busy), 32'd0);
    tick();
    clr           = 1'b0;
    bus.bus_grant = 1'b0;
    tick();
    chk("dclr_done", 32'(bus.done), 32'd0);

    v = '{32'h100, 32'h12345678, 0, 0, 32'h12345678, 1'b0};
    do_read(v);
    chk("sb_drain", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
